// File: rtl/pll_div_pkg.sv
// Shared types for the PLL divider manager: FSM states and per-channel config.
package pll_div_pkg;

  localparam int RATIO_W_DEF = 10;
  // Config fields are held at a fixed width; a top-level RATIO_W must not exceed it.
  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } pll_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] ratio;
    logic [CFG_W-1:0] duty;
    logic [CFG_W-1:0] phase;
  } ch_cfg_t;

  function automatic logic [CFG_W-1:0] eff_ratio(input ch_cfg_t c);
    return (c.ratio < CFG_W'(2)) ? CFG_W'(1) : c.ratio;
  endfunction

  // Ratios of 0/1 collapse to a single-state counter, so the phase is meaningless there.
  function automatic logic [CFG_W-1:0] start_cnt(input ch_cfg_t c);
    return (c.ratio < CFG_W'(2)) ? '0 : c.phase;
  endfunction

endpackage

// File: rtl/pll_div_ch.sv
// One divided clock-enable channel: period counter, shadow config, strobe and duty level.
module pll_div_ch
  import pll_div_pkg::*;
#(
  parameter int DEF_RATIO = 10,
  parameter int DEF_DUTY  = 5,
  parameter int DEF_PHASE = 0
) (
  input  logic    clkin1,
  input  logic    pll_rst,
  input  logic    run,
  input  logic    enter,
  input  logic    resync,
  input  logic    wr,
  input  ch_cfg_t wr_cfg,
  output logic    clk_en,
  output logic    clk_lvl
);

  localparam ch_cfg_t DEF_CFG = '{
    ratio: CFG_W'(DEF_RATIO),
    duty:  CFG_W'(DEF_DUTY),
    phase: CFG_W'(DEF_PHASE)
  };

  ch_cfg_t          act;
  ch_cfg_t          shd;
  ch_cfg_t          next_act;
  ch_cfg_t          enter_cfg;
  logic             pend;
  logic [CFG_W-1:0] cnt;
  logic [CFG_W-1:0] last;

  assign next_act  = pend ? shd : act;
  assign enter_cfg = wr ? wr_cfg : next_act;
  assign last      = eff_ratio(act) - CFG_W'(1);
  assign clk_en    = run && (cnt >= last);
  assign clk_lvl   = run && (cnt < act.duty);

  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      act  <= DEF_CFG;
      shd  <= DEF_CFG;
      pend <= 1'b0;
      cnt  <= '0;
    end else if (enter) begin
      // A write on the entry edge still counts as an outside-RUN write and wins.
      act  <= enter_cfg;
      pend <= 1'b0;
      cnt  <= start_cnt(enter_cfg);
    end else if (!run) begin
      if (wr) begin
        act  <= wr_cfg;
        pend <= 1'b0;
      end
    end else if (resync || clk_en) begin
      act  <= next_act;
      cnt  <= resync ? start_cnt(next_act) : '0;
      pend <= wr;
      if (wr) shd <= wr_cfg;
    end else begin
      cnt <= cnt + CFG_W'(1);
      if (wr) begin
        shd  <= wr_cfg;
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_div_mgr.sv
// PLL divider manager: waits for a settled lock, then runs NUM_CH divided enable channels.
//   state     | meaning
//   WAIT_LOCK | synchronised lock low; channels frozen, outputs 0
//   SETTLE    | lock seen, counting consecutive locked cycles
//   RUN       | lock stable; channels count and drive clk_en/clk_lvl
module pll_div_mgr
  import pll_div_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int RATIO_W   = RATIO_W_DEF,
  parameter int LOCK_WAIT = 1024,
  parameter int DEF_RATIO = 10,
  parameter int DEF_DUTY  = 5,
  parameter int DEF_PHASE = 0
) (
  input  logic               clkin1,
  input  logic               pll_rst,
  input  logic               pll_lock,
  input  logic               resync,
  input  logic               cfg_valid,
  input  logic [2:0]         cfg_ch,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic [RATIO_W-1:0] cfg_duty,
  input  logic [RATIO_W-1:0] cfg_phase,
  output logic               cfg_err,
  output logic [NUM_CH-1:0]  clk_en,
  output logic [NUM_CH-1:0]  clk_lvl,
  output logic               ready,
  output logic               lock_lost
);

  localparam int SET_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;
  // The WAIT_LOCK cycle that sees lock already counts as the first locked cycle.
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'((LOCK_WAIT >= 2) ? LOCK_WAIT - 2 : 0);

  pll_state_e        state;
  pll_state_e        state_nxt;
  logic [SET_W-1:0]  settle_cnt;
  logic [SET_W-1:0]  settle_nxt;
  logic              lock_q1;
  logic              lock_s;
  logic              run;
  logic              enter;
  logic              resync_run;
  logic              cfg_bad;
  logic              cfg_ok;
  logic [NUM_CH-1:0] wr;
  ch_cfg_t           wr_cfg;

  assign run        = (state == RUN);
  assign enter      = (state != RUN) && (state_nxt == RUN);
  assign resync_run = resync && run;
  assign ready      = run;

  assign cfg_bad = (int'(cfg_ch) >= NUM_CH) ||
                   ((cfg_ratio >= RATIO_W'(2)) && (cfg_phase >= cfg_ratio));
  assign cfg_ok  = cfg_valid && !cfg_bad;
  assign wr_cfg  = '{ratio: CFG_W'(cfg_ratio), duty: CFG_W'(cfg_duty), phase: CFG_W'(cfg_phase)};

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt  = SETTLE;
          settle_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          settle_nxt = '0;
        end else if (settle_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          settle_nxt = settle_cnt - SET_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          settle_nxt = '0;
        end
      end
      default: begin
        state_nxt  = WAIT_LOCK;
        settle_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clkin1) begin
    if (pll_rst) begin
      lock_q1    <= 1'b0;
      lock_s     <= 1'b0;
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      lock_lost  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      lock_q1    <= pll_lock;
      lock_s     <= lock_q1;
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      if ((state != WAIT_LOCK) && !lock_s) lock_lost <= 1'b1;
      cfg_err    <= cfg_valid && cfg_bad;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_ok && (cfg_ch == 3'(g));

    pll_div_ch #(
      .DEF_RATIO (DEF_RATIO),
      .DEF_DUTY  (DEF_DUTY),
      .DEF_PHASE (DEF_PHASE)
    ) u_ch (
      .clkin1  (clkin1),
      .pll_rst (pll_rst),
      .run     (run),
      .enter   (enter),
      .resync  (resync_run),
      .wr      (wr[g]),
      .wr_cfg  (wr_cfg),
      .clk_en  (clk_en[g]),
      .clk_lvl (clk_lvl[g])
    );
  end

endmodule

// File: tb/tb_pll_div_mgr.sv
// Self-checking bench for pll_div_mgr: directed scenarios, a cfg vector table and random traffic.
module tb_pll_div_mgr;

  localparam int NCH = 4;
  localparam int LW  = 16;
  localparam int RW  = 10;

  logic           clkin1 = 1'b0;
  logic           pll_rst, pll_lock, resync, cfg_valid;
  logic [2:0]     cfg_ch;
  logic [RW-1:0]  cfg_ratio, cfg_duty, cfg_phase;
  logic           cfg_err, ready, lock_lost;
  logic [NCH-1:0] clk_en, clk_lvl;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clkin1 = ~clkin1;

  pll_div_mgr #(.NUM_CH(NCH), .RATIO_W(RW), .LOCK_WAIT(LW)) dut (
    .clkin1(clkin1), .pll_rst(pll_rst), .pll_lock(pll_lock), .resync(resync),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio), .cfg_duty(cfg_duty),
    .cfg_phase(cfg_phase), .cfg_err(cfg_err), .clk_en(clk_en), .clk_lvl(clk_lvl),
    .ready(ready), .lock_lost(lock_lost)
  );

  // Reference model: lock history as a run length, channels as a position within the period.
  bit m_s1, m_s2, m_run, m_lost, m_err;
  int m_len;
  int m_r[NCH], m_d[NCH], m_p[NCH], m_sr[NCH], m_sd[NCH], m_sp[NCH], m_pos[NCH];
  bit m_pend[NCH];

  function automatic int eff(input int r);
    return (r < 2) ? 1 : r;
  endfunction

  function automatic void model_step();
    bit bad, prev_run, rsy, wr;
    int nxt;
    if (pll_rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0; m_err = 0; m_len = 0;
      for (int i = 0; i < NCH; i++) begin
        m_r[i] = 10; m_d[i] = 5; m_p[i] = 0;
        m_sr[i] = 10; m_sd[i] = 5; m_sp[i] = 0;
        m_pend[i] = 0; m_pos[i] = 0;
      end
      return;
    end
    bad = (int'(cfg_ch) >= NCH) || (int'(cfg_ratio) >= 2 && cfg_phase >= cfg_ratio);
    prev_run = m_run;
    if (m_len > 0 && !m_s2) m_lost = 1;
    m_len = m_s2 ? ((m_len > LW) ? m_len : m_len + 1) : 0;
    m_run = (m_len >= LW);
    m_s2 = m_s1;
    m_s1 = pll_lock;
    m_err = cfg_valid && bad;
    rsy = resync && prev_run;
    for (int i = 0; i < NCH; i++) begin
      wr = cfg_valid && !bad && (int'(cfg_ch) == i);
      if (!prev_run) begin
        if (wr) begin
          m_r[i] = int'(cfg_ratio); m_d[i] = int'(cfg_duty); m_p[i] = int'(cfg_phase);
          m_pend[i] = 0;
        end
        if (m_run) begin
          if (m_pend[i]) begin
            m_r[i] = m_sr[i]; m_d[i] = m_sd[i]; m_p[i] = m_sp[i]; m_pend[i] = 0;
          end
          m_pos[i] = (eff(m_r[i]) == 1) ? 0 : m_p[i];
        end
      end else begin
        nxt = (m_pos[i] + 1) % eff(m_r[i]);
        if (rsy || nxt == 0) begin
          if (m_pend[i]) begin
            m_r[i] = m_sr[i]; m_d[i] = m_sd[i]; m_p[i] = m_sp[i]; m_pend[i] = 0;
          end
          m_pos[i] = (rsy && eff(m_r[i]) > 1) ? m_p[i] : 0;
        end else begin
          m_pos[i] = nxt;
        end
        if (wr) begin
          m_sr[i] = int'(cfg_ratio); m_sd[i] = int'(cfg_duty); m_sp[i] = int'(cfg_phase);
          m_pend[i] = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  task automatic compare_all();
    int en_m, lvl_m;
    en_m = 0; lvl_m = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_run && m_pos[i] == eff(m_r[i]) - 1) en_m |= (1 << i);
      if (m_run && m_pos[i] < m_d[i]) lvl_m |= (1 << i);
    end
    chk("model_ready", int'(ready), int'(m_run));
    chk("model_lock_lost", int'(lock_lost), int'(m_lost));
    chk("model_cfg_err", int'(cfg_err), int'(m_err));
    chk("model_clk_en", int'(clk_en), en_m);
    chk("model_clk_lvl", int'(clk_lvl), lvl_m);
  endtask

  task automatic tick();
    @(posedge clkin1);
    model_step();
    cyc++;
    @(negedge clkin1);
    compare_all();
  endtask

  task automatic wait_ready(input int maxc, output int lat);
    int start;
    start = cyc;
    while (!ready && (cyc - start) < maxc) tick();
    lat = cyc - start;
    chk("ready_within_bound", int'(ready), 1);
  endtask

  task automatic cfg_write(input int ch, input int r, input int d, input int p);
    cfg_valid = 1; cfg_ch = 3'(ch);
    cfg_ratio = RW'(r); cfg_duty = RW'(d); cfg_phase = RW'(p);
    tick();
    cfg_valid = 0;
  endtask

  bit en_h[NCH][64];
  bit lvl_h[NCH][64];

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      for (int i = 0; i < NCH; i++) begin
        en_h[i][k] = clk_en[i];
        lvl_h[i][k] = clk_lvl[i];
      end
    end
  endtask

  task automatic chk_period(input string name, input int ch, input int n,
                            input int period, input int high, input int first);
    int s[$];
    int hc;
    for (int k = 0; k < n; k++) if (en_h[ch][k]) s.push_back(k);
    chk({name, "_two_strobes"}, int'(s.size() >= 2), 1);
    if (first >= 0 && s.size() > 0) chk({name, "_first_strobe"}, s[0], first);
    for (int j = 1; j < s.size(); j++) chk({name, "_gap"}, s[j] - s[j-1], period);
    if (s.size() >= 2) begin
      hc = 0;
      for (int k = s[0] + 1; k <= s[1]; k++) hc += int'(lvl_h[ch][k]);
      chk({name, "_high"}, hc, high);
    end
  endtask

  function automatic int count_hist(input int ch, input int n, input bit use_en);
    int c = 0;
    for (int k = 0; k < n; k++) c += use_en ? int'(en_h[ch][k]) : int'(lvl_h[ch][k]);
    return c;
  endfunction

  typedef struct {
    int ch; int ratio; int duty; int phase; bit exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs[11];

  initial begin
    #200us;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r, p;
    vecs[0]  = '{5, 4, 2, 0, 1};
    vecs[1]  = '{4, 4, 2, 0, 1};
    vecs[2]  = '{7, 3, 1, 0, 1};
    vecs[3]  = '{0, 6, 3, 6, 1};
    vecs[4]  = '{0, 6, 3, 7, 1};
    vecs[5]  = '{0, 6, 3, 5, 0};
    vecs[6]  = '{3, 0, 1, 9, 0};
    vecs[7]  = '{3, 1, 1, 5, 0};
    vecs[8]  = '{1, 5, 0, 2, 0};
    vecs[9]  = '{2, 4, 7, 0, 0};
    vecs[10] = '{0, 8, 3, 7, 0};

    pll_rst = 1; pll_lock = 0; resync = 0; cfg_valid = 0;
    cfg_ch = '0; cfg_ratio = '0; cfg_duty = '0; cfg_phase = '0;
    repeat (3) tick();
    pll_rst = 0;
    tick();
    chk("rst_ready", int'(ready), 0);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_clk_lvl", int'(clk_lvl), 0);
    chk("rst_lock_lost", int'(lock_lost), 0);

    // Lock-up with default configuration
    pll_lock = 1;
    wait_ready(40, lat);
    chk_rng("lockup_latency", lat, LW + 1, LW + 3);
    capture(40);
    for (int i = 0; i < NCH; i++) chk_period("default", i, 40, 10, 5, -1);

    // Reconfigure ch1 mid-period
    for (int k = 0; k < 20 && !clk_en[1]; k++) tick();
    chk("ch1_strobe_seen", int'(clk_en[1]), 1);
    repeat (4) tick();
    cfg_write(1, 4, 1, 0);
    capture(30);
    chk_period("reconfig_ch1", 1, 30, 4, 1, 4);

    // Phase offsets realigned by resync
    cfg_write(0, 8, 4, 0);
    cfg_write(2, 8, 4, 3);
    tick();
    resync = 1;
    tick();
    resync = 0;
    capture(30);
    chk_period("resync_ch2", 2, 30, 8, 4, 3);
    chk_period("resync_ch0", 0, 30, 8, 4, 6);

    // Rejected writes while running
    cfg_write(5, 3, 1, 0);
    chk("err_bad_ch_pulse", int'(cfg_err), 1);
    tick();
    chk("err_bad_ch_clear", int'(cfg_err), 0);
    cfg_write(0, 6, 3, 6);
    chk("err_bad_phase_pulse", int'(cfg_err), 1);
    tick();
    chk("err_bad_phase_clear", int'(cfg_err), 0);
    capture(20);
    chk_period("after_err_ch0", 0, 20, 8, 4, -1);

    // Vector table of writes outside RUN, then edge ratios/duties
    pll_lock = 0; pll_rst = 1;
    repeat (2) tick();
    pll_rst = 0;
    tick();
    for (int v = 0; v < 11; v++) begin
      cfg_write(vecs[v].ch, vecs[v].ratio, vecs[v].duty, vecs[v].phase);
      chk($sformatf("vec%0d_cfg_err", v), int'(cfg_err), int'(vecs[v].exp_err));
    end
    pll_lock = 1;
    wait_ready(40, lat);
    capture(24);
    chk("ratio1_en_const", count_hist(3, 24, 1), 24);
    chk("duty0_lvl_const", count_hist(1, 24, 0), 0);
    chk("duty_ge_ratio_lvl_const", count_hist(2, 24, 0), 24);
    chk_period("phase7_ch0", 0, 24, 8, 3, -1);
    pll_rst = 1;
    tick();
    chk("rst_run_ready", int'(ready), 0);
    chk("rst_run_clk_en", int'(clk_en), 0);
    chk("rst_run_clk_lvl", int'(clk_lvl), 0);
    chk("rst_run_cfg_err", int'(cfg_err), 0);
    chk("rst_run_lock_lost", int'(lock_lost), 0);

    // One-cycle lock glitch during SETTLE
    pll_lock = 0;
    tick();
    pll_rst = 0;
    tick();
    pll_lock = 1;
    repeat (12) tick();
    chk("glitch_pre_ready", int'(ready), 0);
    chk("glitch_pre_lost", int'(lock_lost), 0);
    pll_lock = 0;
    tick();
    pll_lock = 1;
    wait_ready(50, lat);
    chk_rng("glitch_relock_latency", lat, LW + 1, LW + 3);
    chk("glitch_lock_lost", int'(lock_lost), 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cfg_valid = ($urandom % 4) == 0;
      cfg_ch = 3'($urandom_range(0, 5));
      r = $urandom_range(0, 12);
      if ($urandom % 5 == 0) p = $urandom_range(r, r + 3);
      else p = (r > 1) ? $urandom_range(0, r - 1) : $urandom_range(0, 3);
      cfg_ratio = RW'(r);
      cfg_phase = RW'(p);
      cfg_duty = RW'($urandom_range(0, 13));
      resync = ($urandom % 16) == 0;
      pll_lock = ($urandom % 64) != 0;
      tick();
    end
    cfg_valid = 0; resync = 0; pll_lock = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
